mem_stage: RTL and testbench

- Memory-access stage; consumes the memory request emitted by the execute functional unit (MEM_REQUIRE fields, flattened here) one instruction at a time.
- Performs the word load/store on the data-memory bus with a req/ack handshake, with timeout and alignment checks.
- Emits a single-cycle writeback record to the register-file write port.
- Stalls the upstream stage via in_ready while a bus access is outstanding.

---
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle of the upstream request, data-memory bus and writeback port around mem_stage.
// The master side belongs to the stage and the slave side to its environment.
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read_ena;
  logic        mem_write_ena;
  logic        write_reg_need;
  logic [4:0]  write_reg_addr;
  logic [31:0] result;
  logic [31:0] write_data;
  logic [31:0] addr;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_reg_we;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;
  logic        mem_err;
  logic        bus_err;

  modport master (
    input  in_valid, mem_read_ena, mem_write_ena, write_reg_need, write_reg_addr,
           result, write_data, addr, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_reg_we, wb_reg_addr, wb_data, mem_err, bus_err
  );

  modport slave (
    output in_valid, mem_read_ena, mem_write_ena, write_reg_need, write_reg_addr,
           result, write_data, addr, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_reg_we, wb_reg_addr, wb_data, mem_err, bus_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one instruction at a time, word load/store over a req/ack bus
// with alignment and timeout checks, producing a one-cycle writeback record.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master bus
);
  typedef enum logic {IDLE, BUS} state_t;

  // What the writeback needs once the bus access finishes.
  typedef struct packed {
    logic        load;
    logic        reg_we;
    logic [31:0] result;
  } pend_t;

  state_t           state;
  pend_t            pend;
  logic [CNT_W-1:0] cnt;

  logic is_mem, illegal, reg_we_in, timeout;

  assign bus.in_ready = (state == IDLE);
  assign is_mem    = bus.mem_read_ena | bus.mem_write_ena;
  assign illegal   = (bus.mem_read_ena & bus.mem_write_ena) | (is_mem & (bus.addr[1:0] != 2'b00));
  assign reg_we_in = bus.write_reg_need & (bus.write_reg_addr != 5'd0);
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pend            <= '0;
      cnt             <= '0;
      bus.dmem_req    <= 1'b0;
      bus.dmem_we     <= 1'b0;
      bus.dmem_addr   <= '0;
      bus.dmem_wdata  <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_reg_we   <= 1'b0;
      bus.wb_reg_addr <= '0;
      bus.wb_data     <= '0;
      bus.mem_err     <= 1'b0;
      bus.bus_err     <= 1'b0;
    end else begin
      bus.wb_valid  <= 1'b0;
      bus.wb_reg_we <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.wb_reg_addr <= bus.write_reg_addr;
            if (illegal) begin
              bus.wb_valid <= 1'b1;
              bus.mem_err  <= 1'b1;
              bus.wb_data  <= bus.result;
            end else if (!is_mem) begin
              bus.wb_valid  <= 1'b1;
              bus.wb_reg_we <= reg_we_in;
              bus.wb_data   <= bus.result;
            end else begin
              state          <= BUS;
              cnt            <= '0;
              pend.load      <= bus.mem_read_ena;
              pend.reg_we    <= reg_we_in;
              pend.result    <= bus.result;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.mem_write_ena;
              bus.dmem_addr  <= {bus.addr[31:2], 2'b00};
              bus.dmem_wdata <= bus.write_data;
            end
          end
        end
        BUS: begin
          // An ack on the last allowed cycle still completes the access.
          if (bus.dmem_ack) begin
            state         <= IDLE;
            bus.dmem_req  <= 1'b0;
            bus.wb_valid  <= 1'b1;
            bus.wb_reg_we <= pend.load & pend.reg_we;
            bus.wb_data   <= pend.load ? bus.dmem_rdata : pend.result;
          end else if (timeout) begin
            state        <= IDLE;
            bus.dmem_req <= 1'b0;
            bus.wb_valid <= 1'b1;
            bus.bus_err  <= 1'b1;
            bus.wb_data  <= pend.result;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts every writeback
// record and bus cycle; literal checks pin the model on the planned scenarios.
module tb_mem_stage;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Expected writeback record, visible in the cycle after edge 'due'.
  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  ra;
    logic [31:0] data;
    bit          cd;
    logic        merr;
    logic        berr;
  } rec_t;

  rec_t        exq[$];
  bit          m_pend = 0;
  int          m_wait;
  bit          m_load, m_rwe, m_wr;
  logic [4:0]  m_ra;
  logic [31:0] m_res, m_addr, m_wd;

  // Model: advance one transaction-level step per rising edge.
  always @(posedge clk) begin
    bit is_mem, bad;
    edge_n++;
    if (rst) begin
      m_pend = 0;
      exq.delete();
    end else if (m_pend) begin
      if (bus.dmem_ack) begin
        exq.push_back('{edge_n, m_load & m_rwe, m_ra, m_load ? bus.dmem_rdata : m_res, 1'b1, 1'b0, 1'b0});
        m_pend = 0;
      end else if (m_wait == TO - 1) begin
        exq.push_back('{edge_n, 1'b0, m_ra, 32'h0, 1'b0, 1'b0, 1'b1});
        m_pend = 0;
      end else begin
        m_wait++;
      end
    end else if (bus.in_valid) begin
      is_mem = bus.mem_read_ena | bus.mem_write_ena;
      bad    = (bus.mem_read_ena & bus.mem_write_ena) | (is_mem && bus.addr[1:0] != 2'b00);
      if (bad)
        exq.push_back('{edge_n, 1'b0, bus.write_reg_addr, 32'h0, 1'b0, 1'b1, 1'b0});
      else if (!is_mem)
        exq.push_back('{edge_n, bus.write_reg_need && bus.write_reg_addr != 0,
                        bus.write_reg_addr, bus.result, 1'b1, 1'b0, 1'b0});
      else begin
        m_pend = 1;
        m_wait = 0;
        m_load = bus.mem_read_ena;
        m_wr   = bus.mem_write_ena;
        m_rwe  = bus.write_reg_need && bus.write_reg_addr != 0;
        m_ra   = bus.write_reg_addr;
        m_res  = bus.result;
        m_addr = bus.addr;
        m_wd   = bus.write_data;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    rec_t r;
    if (edge_n > 0) begin
      chk("in_ready", bus.in_ready, !m_pend);
      chk("dmem_req", bus.dmem_req, m_pend);
      if (m_pend) begin
        chk("dmem_addr", bus.dmem_addr, m_addr);
        chk("dmem_we", bus.dmem_we, m_wr);
        chk("dmem_wdata", bus.dmem_wdata, m_wd);
      end
      if (exq.size() > 0 && exq[0].due == edge_n) begin
        r = exq.pop_front();
        chk("wb_valid", bus.wb_valid, 1'b1);
        chk("wb_reg_we", bus.wb_reg_we, r.we);
        chk("wb_reg_addr", bus.wb_reg_addr, r.ra);
        chk("mem_err", bus.mem_err, r.merr);
        chk("bus_err", bus.bus_err, r.berr);
        if (r.cd) chk("wb_data", bus.wb_data, r.data);
      end else begin
        chk("wb_valid_idle", bus.wb_valid, 1'b0);
        chk("mem_err_idle", bus.mem_err, 1'b0);
        chk("bus_err_idle", bus.bus_err, 1'b0);
      end
    end
  end

  task automatic drive(input bit rd, wr, need, input logic [4:0] ra,
                       input logic [31:0] res, wd, ad);
    bus.in_valid       = 1'b1;
    bus.mem_read_ena   = rd;
    bus.mem_write_ena  = wr;
    bus.write_reg_need = need;
    bus.write_reg_addr = ra;
    bus.result         = res;
    bus.write_data     = wd;
    bus.addr           = ad;
  endtask

  // Issue one bus op; ack on req cycle ack_cyc (0 = never). Returns at the record cycle.
  task automatic bus_op(input bit rd, wr, need, input logic [4:0] ra,
                        input logic [31:0] res, wd, ad, input int ack_cyc,
                        input logic [31:0] rdat);
    drive(rd, wr, need, ra, res, wd, ad);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= ((ack_cyc != 0) ? ack_cyc : TO); i++) begin
      if (i == ack_cyc) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdat;
      end
      @(negedge clk);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h0BAD_0BAD;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.mem_read_ena = 0; bus.mem_write_ena = 0;
    bus.write_reg_need = 0; bus.write_reg_addr = 0; bus.result = 0;
    bus.write_data = 0; bus.addr = 0; bus.dmem_ack = 0; bus.dmem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_dmem_addr", bus.dmem_addr, 32'h0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_wb_reg_addr", bus.wb_reg_addr, 5'd0);
    rst = 1'b0;

    // ALU passthrough, three back-to-back
    drive(0, 0, 1, 5'd5, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_wb_valid", bus.wb_valid, 1'b1);
      chk("alu_wb_data", bus.wb_data, 32'h1234_5678);
      chk("alu_in_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 0;
    @(negedge clk);

    // Load, ack on 3rd req cycle
    bus_op(1, 0, 1, 5'd7, 32'h0, 32'h0, 32'h100, 3, 32'hDEAD_BEEF);
    chk("ld_wb_valid", bus.wb_valid, 1'b1);
    chk("ld_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_reg_we", bus.wb_reg_we, 1'b1);
    chk("ld_wb_reg_addr", bus.wb_reg_addr, 5'd7);
    @(negedge clk);

    // Store, immediate ack
    bus_op(0, 1, 1, 5'd3, 32'h55, 32'hA5A5_A5A5, 32'h200, 1, 32'h0);
    chk("st_wb_reg_we", bus.wb_reg_we, 1'b0);
    chk("st_wb_data", bus.wb_data, 32'h55);

    // Load to r0 never writes, issued right on the previous record cycle
    bus_op(1, 0, 1, 5'd0, 32'h0, 32'h0, 32'h40, 2, 32'h1111_2222);
    chk("ld_r0_wb_reg_we", bus.wb_reg_we, 1'b0);
    @(negedge clk);

    // Misaligned load, then both enables at aligned address
    drive(1, 0, 1, 5'd4, 32'h9, 32'h0, 32'h102);
    @(negedge clk);
    bus.in_valid = 0;
    chk("mis_mem_err", bus.mem_err, 1'b1);
    chk("mis_wb_reg_we", bus.wb_reg_we, 1'b0);
    chk("mis_dmem_req", bus.dmem_req, 1'b0);
    drive(1, 1, 1, 5'd4, 32'h9, 32'h0, 32'h300);
    @(negedge clk);
    bus.in_valid = 0;
    chk("both_mem_err", bus.mem_err, 1'b1);
    chk("both_dmem_req", bus.dmem_req, 1'b0);
    @(negedge clk);

    // Timeout: no ack ever
    bus_op(1, 0, 1, 5'd9, 32'h0, 32'h0, 32'h400, 0, 32'h0);
    chk("to_bus_err", bus.bus_err, 1'b1);
    chk("to_wb_reg_we", bus.wb_reg_we, 1'b0);
    chk("to_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // Ack on the last allowed cycle wins, then an ALU op accepted on the record cycle
    bus_op(1, 0, 1, 5'd10, 32'h0, 32'h0, 32'h404, TO, 32'hCAFE_F00D);
    chk("ackto_bus_err", bus.bus_err, 1'b0);
    chk("ackto_wb_data", bus.wb_data, 32'hCAFE_F00D);
    drive(0, 0, 1, 5'd11, 32'h7777_0000, 0, 0);
    @(negedge clk);
    bus.in_valid = 0;
    chk("b2b_wb_data", bus.wb_data, 32'h7777_0000);
    @(negedge clk);

    // Reset during cycle 2 of a pending load; late ack ignored
    drive(1, 0, 1, 5'd12, 32'h0, 32'h0, 32'h500);
    @(negedge clk);
    bus.in_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstbus_dmem_req", bus.dmem_req, 1'b0);
    chk("rstbus_in_ready", bus.in_ready, 1'b1);
    chk("rstbus_wb_valid", bus.wb_valid, 1'b0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1234_4321;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    chk("late_ack_wb_valid", bus.wb_valid, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
